// File: rtl/seg7_pkg.sv
// Shared constants, buffer FSM states and the display-content payload
// for the 8-digit seven-segment scan driver.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned SCAN_W     = 3;
   localparam int unsigned WORD_W     = NUM_DIGITS * DIGIT_W;

   localparam logic [NUM_DIGITS-1:0] LES_RST  = 8'hFF;
   localparam logic [WORD_W-1:0]     DISP_RST = 32'h0;

   typedef enum logic {
      BUF_IDLE    = 1'b0,
      BUF_PENDING = 1'b1
   } buf_state_e;

   // One complete set of display content, held in both shadow and active banks
   typedef struct packed {
      logic [WORD_W-1:0]     data;
      logic [NUM_DIGITS-1:0] point;
      logic [NUM_DIGITS-1:0] blank;
      logic [NUM_DIGITS-1:0] blink_en;
      logic                  lzs_en;
   } disp_cfg_t;

   localparam disp_cfg_t CFG_RST = '{
      data:     DISP_RST,
      point:    '0,
      blank:    LES_RST,
      blink_en: '0,
      lzs_en:   1'b0
   };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load handshake and display-device signals of the seven-segment scan driver.
interface seg7_scan_driver_if;
   import seg7_pkg::*;

   logic                  load;
   logic                  load_ready;
   logic [WORD_W-1:0]     data_in;
   logic [NUM_DIGITS-1:0] point_in;
   logic [NUM_DIGITS-1:0] blank_in;
   logic [NUM_DIGITS-1:0] blink_en;
   logic                  lzs_en;
   logic [WORD_W-1:0]     disp_num;
   logic [NUM_DIGITS-1:0] point;
   logic [NUM_DIGITS-1:0] les;
   logic [SCAN_W-1:0]     scan;
   logic                  frame_tick;
   logic                  upd_done;

   modport master (
      output load, data_in, point_in, blank_in, blink_en, lzs_en,
      input  load_ready, disp_num, point, les, scan, frame_tick, upd_done
   );

   modport slave (
      input  load, data_in, point_in, blank_in, blink_en, lzs_en,
      output load_ready, disp_num, point, les, scan, frame_tick, upd_done
   );

endinterface

// File: rtl/seg7_lzs_mask.sv
// Leading-zero suppression mask: blanks digits 7..1 while their nibble is zero,
// stopping at the first nonzero nibble. Digit 0 is always shown.
module seg7_lzs_mask
   import seg7_pkg::*;
(
   input  logic [WORD_W-1:0]     word,
   input  logic                  en,
   output logic [NUM_DIGITS-1:0] mask_c
);

   logic run;

   always_comb begin
      mask_c = '0;
      run    = en;
      for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
         if (run && (word[i*DIGIT_W +: DIGIT_W] == '0)) begin
            mask_c[i] = 1'b1;
         end else begin
            run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scan index generator with frame-synchronous double-buffered display content,
// per-digit blink and leading-zero suppression for an 8-digit 7-segment display.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 100000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic               clk,
   input  logic               rstn,
   seg7_scan_driver_if.slave  bus
);

   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
   localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]      presc;
   logic [SCAN_W-1:0]     scan_q;
   logic                  frame_tick_q;
   logic [BLK_W-1:0]      blink_cnt;
   logic                  blink_phase;
   buf_state_e            state;
   buf_state_e            state_nxt;
   logic                  load_ready_q;
   logic                  upd_done_q;
   disp_cfg_t             shadow;
   disp_cfg_t             active;
   logic [NUM_DIGITS-1:0] les_q;
   logic [NUM_DIGITS-1:0] lzs_mask_c;
   logic                  slot_tick_c;
   logic                  wrap_c;
   logic                  accept_c;
   logic                  commit_c;

   assign slot_tick_c = (presc == PRE_LAST);
   assign wrap_c      = slot_tick_c && (scan_q == SCAN_LAST);

   // Prescaler and digit scan; frame_tick marks the cycle scan returns to 0
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         presc        <= '0;
         scan_q       <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         presc        <= slot_tick_c ? '0 : presc + PRE_W'(1);
         frame_tick_q <= wrap_c;
         if (slot_tick_c) begin
            scan_q <= scan_q + SCAN_W'(1);
         end
      end
   end

   // Blink phase flips once every BLINK_FRAMES frames
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (wrap_c) begin
         if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
         end
      end
   end

   // Buffer FSM: a committed shadow only ever lands on a frame wrap
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      commit_c  = 1'b0;
      case (state)
         BUF_IDLE: begin
            if (bus.load) begin
               accept_c  = 1'b1;
               state_nxt = BUF_PENDING;
            end
         end
         BUF_PENDING: begin
            if (wrap_c) begin
               commit_c  = 1'b1;
               state_nxt = BUF_IDLE;
            end
         end
         default: state_nxt = BUF_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= BUF_IDLE;
         load_ready_q <= 1'b1;
         upd_done_q   <= 1'b0;
         shadow       <= CFG_RST;
         active       <= CFG_RST;
      end else begin
         state        <= state_nxt;
         load_ready_q <= (state_nxt == BUF_IDLE);
         upd_done_q   <= commit_c;
         if (accept_c) begin
            shadow <= '{
               data:     bus.data_in,
               point:    bus.point_in,
               blank:    bus.blank_in,
               blink_en: bus.blink_en,
               lzs_en:   bus.lzs_en
            };
         end
         if (commit_c) begin
            active <= shadow;
         end
      end
   end

   seg7_lzs_mask u_lzs (
      .word   (active.data),
      .en     (active.lzs_en),
      .mask_c (lzs_mask_c)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         les_q <= LES_RST;
      end else begin
         les_q <= active.blank
                | (active.blink_en & {NUM_DIGITS{blink_phase}})
                | lzs_mask_c;
      end
   end

   assign bus.load_ready = load_ready_q;
   assign bus.disp_num   = active.data;
   assign bus.point      = active.point;
   assign bus.les        = les_q;
   assign bus.scan       = scan_q;
   assign bus.frame_tick = frame_tick_q;
   assign bus.upd_done   = upd_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg7_scan_driver;

   localparam int unsigned SCAN_DIV     = 4;
   localparam int unsigned BLINK_FRAMES = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(
      .SCAN_DIV     (SCAN_DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] disp;
      logic [7:0]  pt;
      logic [7:0]  les;
      bit          chk_les;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Expected suppression mask: everything above the most significant nonzero digit
   function automatic logic [7:0] model_lzs(input logic [31:0] w, input logic en);
      int          top;
      logic [15:0] ones;
      top  = 0;
      ones = 16'h00FF;
      for (int d = 0; d < 8; d++) begin
         if (((w >> (4 * d)) & 32'hF) != 32'h0) top = d;
      end
      if (!en) return 8'h00;
      return 8'(ones << (top + 1));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_scan(input logic [2:0] s, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.scan == s) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_upd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.upd_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b,
                          input logic [7:0] bl, input logic lz);
      bus.data_in  = d;
      bus.point_in = p;
      bus.blank_in = b;
      bus.blink_en = bl;
      bus.lzs_en   = lz;
      bus.load     = 1'b1;
      tick();
      bus.load     = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (bus.les !== 8'hFF || bus.disp_num !== 32'h0 || bus.point !== 8'h00) begin
         n_err++;
         $display("FAIL reset_data: les=%h disp=%h point=%h, want FF 00000000 00",
                  bus.les, bus.disp_num, bus.point);
      end
      n_vec++;
      if (bus.scan !== 3'd0 || bus.load_ready !== 1'b1 || bus.frame_tick !== 1'b0 ||
          bus.upd_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: scan=%0d rdy=%b ft=%b upd=%b, want 0 1 0 0",
                  bus.scan, bus.load_ready, bus.frame_tick, bus.upd_done);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_scan();
      logic [2:0] exp_scan;
      logic       exp_ft;
      for (int k = 1; k <= 70; k++) begin
         tick();
         exp_scan = 3'((k / 4) % 8);
         exp_ft   = ((k % 32) == 0);
         n_vec++;
         if (bus.scan !== exp_scan || bus.frame_tick !== exp_ft) begin
            n_err++;
            $display("FAIL scan_step k=%0d: scan=%0d ft=%b, want %0d %b",
                     k, bus.scan, bus.frame_tick, exp_scan, exp_ft);
         end
         n_vec++;
         if (bus.les !== 8'hFF || bus.disp_num !== 32'h0) begin
            n_err++;
            $display("FAIL idle_out k=%0d: les=%h disp=%h, want FF 0", k, bus.les, bus.disp_num);
         end
      end
   endtask

   task automatic test_load_commit();
      bit   ok;
      exp_t e;
      wait_scan(3'd3, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL load_wait_scan: scan=%0d, want 3 within budget", bus.scan);
      end
      do_load(32'h1234ABCD, 8'h01, 8'h00, 8'h00, 1'b0);
      sb.push_back('{disp: 32'h1234ABCD, pt: 8'h01, les: 8'h00, chk_les: 1'b1});
      n_vec++;
      if (bus.load_ready !== 1'b0 || bus.disp_num !== 32'h0) begin
         n_err++;
         $display("FAIL load_accept: rdy=%b disp=%h, want 0 00000000", bus.load_ready, bus.disp_num);
      end
      tick();
      do_load(32'hFFFFFFFF, 8'hFF, 8'hFF, 8'h00, 1'b0);
      n_vec++;
      if (bus.load_ready !== 1'b0 || bus.disp_num !== 32'h0) begin
         n_err++;
         $display("FAIL ignored_load: rdy=%b disp=%h, want 0 00000000", bus.load_ready, bus.disp_num);
      end
      wait_upd(ok);
      n_vec++;
      if (!ok || sb.size() == 0) begin
         n_err++;
         $display("FAIL commit_timeout: upd_done=%b, want 1 within budget", bus.upd_done);
      end else begin
         e = sb.pop_front();
         n_vec++;
         if (bus.disp_num !== e.disp || bus.point !== e.pt || bus.load_ready !== 1'b1 ||
             bus.scan !== 3'd0) begin
            n_err++;
            $display("FAIL commit_out: disp=%h pt=%h rdy=%b scan=%0d, want %h %h 1 0",
                     bus.disp_num, bus.point, bus.load_ready, bus.scan, e.disp, e.pt);
         end
         tick();
         n_vec++;
         if (bus.upd_done !== 1'b0 || (e.chk_les && bus.les !== e.les)) begin
            n_err++;
            $display("FAIL commit_les: upd=%b les=%h, want 0 %h", bus.upd_done, bus.les, e.les);
         end
      end
   endtask

   task automatic test_lzs();
      logic [31:0] td[4];
      logic [7:0]  tb_[4];
      bit          ok;
      exp_t        e;
      td[0] = 32'h00000A00; tb_[0] = 8'h00;
      td[1] = 32'h00000000; tb_[1] = 8'h00;
      td[2] = 32'h00000A00; tb_[2] = 8'h01;
      td[3] = 32'h80000000; tb_[3] = 8'h00;
      for (int t = 0; t < 4; t++) begin
         wait_scan(3'd5, ok);
         do_load(td[t], 8'h00, tb_[t], 8'h00, 1'b1);
         sb.push_back('{disp: td[t], pt: 8'h00, les: tb_[t] | model_lzs(td[t], 1'b1),
                        chk_les: 1'b1});
         wait_upd(ok);
         n_vec++;
         if (!ok || sb.size() == 0) begin
            n_err++;
            $display("FAIL lzs_commit_timeout t=%0d: upd_done=%b, want 1", t, bus.upd_done);
         end else begin
            e = sb.pop_front();
            n_vec++;
            if (bus.disp_num !== e.disp || bus.load_ready !== 1'b1) begin
               n_err++;
               $display("FAIL lzs_commit t=%0d: disp=%h rdy=%b, want %h 1",
                        t, bus.disp_num, bus.load_ready, e.disp);
            end
            tick();
            n_vec++;
            if (bus.les !== e.les) begin
               n_err++;
               $display("FAIL lzs_les t=%0d: les=%h, want %h", t, bus.les, e.les);
            end
         end
      end
   endtask

   task automatic test_blink();
      bit         ok;
      exp_t       e;
      logic [7:0] prev;
      int         last_chg;
      int         n_chg;
      wait_scan(3'd2, ok);
      do_load(32'h89ABCDEF, 8'h00, 8'h00, 8'h0F, 1'b0);
      sb.push_back('{disp: 32'h89ABCDEF, pt: 8'h00, les: 8'h00, chk_les: 1'b0});
      wait_upd(ok);
      n_vec++;
      if (!ok || sb.size() == 0) begin
         n_err++;
         $display("FAIL blink_commit_timeout: upd_done=%b, want 1", bus.upd_done);
         return;
      end
      e = sb.pop_front();
      n_vec++;
      if (bus.disp_num !== e.disp) begin
         n_err++;
         $display("FAIL blink_commit: disp=%h, want %h", bus.disp_num, e.disp);
      end
      tick();
      prev     = bus.les;
      last_chg = -1;
      n_chg    = 0;
      for (int i = 0; i < 260; i++) begin
         tick();
         n_vec++;
         if (bus.les !== 8'h00 && bus.les !== 8'h0F) begin
            n_err++;
            $display("FAIL blink_value i=%0d: les=%h, want 00 or 0F", i, bus.les);
         end
         if (bus.les !== prev) begin
            if (last_chg >= 0) begin
               n_vec++;
               if (i - last_chg != 64) begin
                  n_err++;
                  $display("FAIL blink_period: interval=%0d, want 64", i - last_chg);
               end
            end
            last_chg = i;
            n_chg++;
            prev = bus.les;
         end
      end
      n_vec++;
      if (n_chg < 4) begin
         n_err++;
         $display("FAIL blink_toggles: toggles=%0d, want >=4", n_chg);
      end
   endtask

   task automatic test_reset_mid_pending();
      bit ok;
      int n_upd;
      wait_scan(3'd2, ok);
      tick();
      do_load(32'h55555555, 8'hAA, 8'h00, 8'h00, 1'b0);
      sb.push_back('{disp: 32'h55555555, pt: 8'hAA, les: 8'h00, chk_les: 1'b1});
      n_vec++;
      if (bus.load_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_pend_accept: rdy=%b, want 0", bus.load_ready);
      end
      #2;
      rstn = 1'b0;
      #1;
      sb.delete();
      n_vec++;
      if (bus.load_ready !== 1'b1 || bus.les !== 8'hFF || bus.disp_num !== 32'h0 ||
          bus.point !== 8'h00 || bus.scan !== 3'd0 || bus.upd_done !== 1'b0) begin
         n_err++;
         $display("FAIL rst_async: rdy=%b les=%h disp=%h pt=%h scan=%0d upd=%b, want 1 FF 0 0 0 0",
                  bus.load_ready, bus.les, bus.disp_num, bus.point, bus.scan, bus.upd_done);
      end
      @(negedge clk);
      rstn  = 1'b1;
      n_upd = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (bus.upd_done === 1'b1) n_upd++;
      end
      n_vec++;
      if (n_upd != 0 || bus.disp_num !== 32'h0 || bus.les !== 8'hFF || bus.load_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_no_commit: upd_count=%0d disp=%h les=%h rdy=%b, want 0 0 FF 1",
                  n_upd, bus.disp_num, bus.les, bus.load_ready);
      end
   endtask

   initial begin
      bus.load     = 1'b0;
      bus.data_in  = 32'h0;
      bus.point_in = 8'h00;
      bus.blank_in = 8'h00;
      bus.blink_en = 8'h00;
      bus.lzs_en   = 1'b0;
      test_reset();
      test_scan();
      test_load_commit();
      test_lzs();
      test_blink();
      test_reset_mid_pending();
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Sequential front end for the 8-digit seven-segment display device. Generates the 3-bit digit scan index from the system clock and double-buffers the display word, decimal points and blanking mask. Updates are applied only at frame boundaries, so the display never tears. It also produces per-digit blink and leading-zero suppression, and drives the display device's disp_num/point/les/scan inputs directly.

Parameters:
SCAN_DIV, 100000, clocks per digit slot (>=2); prescaler terminal count is SCAN_DIV-1
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  reset, asynchronous, active-low
load  in  1  request to capture new display content; accepted when load && load_ready
load_ready  out  1  high when shadow buffer is free
data_in  in  32  eight hex nibbles; digit7 = [31:28], digit0 = [3:0]
point_in  in  8  decimal point per digit, 1 = lit
blank_in  in  8  static per-digit blank, 1 = blanked
blink_en  in  8  per-digit blink enable, sampled with load
lzs_en  in  1  leading-zero suppression enable, sampled with load
disp_num  out  32  active display word
point  out  8  active decimal points
les  out  8  per-digit blank to display device, 1 = blanked
scan  out  3  current digit index
frame_tick  out  1  one-cycle pulse when scan wraps 7->0
upd_done  out  1  one-cycle pulse when shadow is committed to active

Behaviour:
- Reset (rstn low, async) values: scan=0, prescaler=0, blink counter=0, blink_phase=0, disp_num=0, point=0, les=8'hFF, load_ready=1, frame_tick=0, upd_done=0. Shadow and active data=0, blank=8'hFF, blink_en=0, lzs_en=0, pending=0. All outputs are registered.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. slot_tick is asserted when prescaler==SCAN_DIV-1.
- On slot_tick, scan<=scan+1 (mod 8). frame_tick=1 in the cycle scan becomes 0.
- Blink: blink counter counts frame_ticks 0..BLINK_FRAMES-1. blink_phase toggles on the frame_tick that wraps the counter.
- Load handshake: when load && load_ready, all inputs are captured into shadow, pending<=1 and load_ready<=0. load while load_ready=0 is ignored, with no side effects.
- Commit: in the cycle scan wraps to 0, if pending=1 (state before that edge): active<=shadow, pending<=0, load_ready<=1, upd_done=1 for that cycle.
- A load accepted on the same edge as a wrap is committed at the following wrap, not the current one.
- disp_num and point reflect the active registers.
- LZS mask: when active lzs_en=1, digits 7 down to 1 are masked while their nibble is 0, stopping at the first nonzero nibble. Digit 0 is never masked.
- les = active_blank | (active_blink_en & {8{blink_phase}}) | lzs_mask, registered and updated every cycle.
- Boundary cases:
  - SCAN_DIV=2 gives a slot every 2 clocks.
  - BLINK_FRAMES=1 toggles blink_phase every frame.
  - All-zero data with lzs gives les=8'hFE (plus static blank bits).
  - rstn mid-pending discards the shadow, and no upd_done follows.
- State machine (buffer): IDLE (load_ready=1) -> PENDING on accepted load; PENDING -> IDLE on frame wrap with commit.

Decomposition:
- Package seg7_pkg: NUM_DIGITS=8, DIGIT_W=4, SCAN_W=3, reset constants LES_RST=8'hFF and DISP_RST=32'h0.
- One combinational sub-module, seg7_lzs_mask: input 32-bit word and enable, output 8-bit mask. This keeps the suppression rule independently testable.
- Prescaler, blink counter and buffer FSM live in the top module.

Test Plan:
All scenarios use SCAN_DIV=4 and BLINK_FRAMES=2.
1. Reset release, no load -> scan steps 0..7 every 4 clocks; frame_tick pulses every 32 clocks; les stays 8'hFF; disp_num stays 0.
2. Mid-frame load of data_in=32'h1234ABCD, point_in=8'h01, blank_in=0 -> load_ready=0 the next cycle; outputs unchanged until scan wraps. Then disp_num=32'h1234ABCD, point=8'h01, les=8'h00, upd_done one cycle, load_ready=1.
3. Second load while pending, with data 32'hFFFFFFFF -> ignored; the commit still shows 32'h1234ABCD.
4. lzs_en=1 with data_in=32'h00000A00 -> after commit, les=8'hF8. With data_in=0 -> les=8'hFE.
5. blink_en=8'h0F, blank_in=0 -> after commit, les alternates 8'h00 / 8'h0F, toggling every 64 clocks.
6. rstn pulsed low while pending (mid-slot) -> immediate reset values, load_ready=1, and no upd_done at the next wrap.
